// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int regfile_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sweep: steps a counter over every register address, then
// moves to RUN and raises READY.
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_ready
);

    localparam int              DEPTH    = regfile_depth(ADDR_W);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter is one bit wider than the address so it parks at DEPTH in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        o_clr_we   = (r_state == ST_INIT);
        o_clr_addr = r_cnt[ADDR_W-1:0];
        o_ready    = (r_state == ST_RUN);
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, one write port,
// optional hardwired zero register, clear sweep after reset.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD-1:0]        i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_valid,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_wa,
    input  logic [DATA_W-1:0]        i_wd,
    output logic                     o_ready
);

    localparam int DEPTH = regfile_depth(ADDR_W);

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;
    logic              w_user_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_wa;
    logic [DATA_W-1:0] w_wd;

    logic [DATA_W-1:0] r_regs [DEPTH];

    regfile_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_ready)
    );

    assign o_ready = w_ready;

    // User writes only land in RUN; the clear sweep owns the port during INIT.
    always_comb begin
        w_user_we = w_ready && i_we && !((ZERO_REG != 0) && (i_wa == '0));
        w_we      = w_clr_we || w_user_we;
        w_wa      = w_clr_we ? w_clr_addr : i_wa;
        w_wd      = w_clr_we ? '0 : i_wd;
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_regs[w_wa] <= w_wd;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_val;
        logic [DATA_W-1:0] r_data;
        logic              r_valid;

        assign w_addr = i_rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_val = r_regs[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_ready && i_we && (i_wa == w_addr)) begin
                w_val = i_wd;
            end
`endif
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_val = '0;
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_ready && i_rd_en[p];
                if (w_ready && i_rd_en[p]) begin
                    r_data <= w_val;
                end
            end
        end

        assign o_rd_data[p*DATA_W +: DATA_W] = r_data;
        assign o_rd_valid[p]                 = r_valid;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp (3 read ports) against an array-based model.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 3;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_RD-1:0]        rd_en = '0;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     we = 1'b0;
    logic [ADDR_W-1:0]        wa = '0;
    logic [DATA_W-1:0]        wd = '0;
    logic                     ready;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem       [DEPTH];
    logic [31:0] exp_data  [NUM_RD];
    logic        exp_valid [NUM_RD];
    int          edges_since_rst;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_we       (we),
        .i_wa       (wa),
        .i_wd       (wd),
        .o_ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input int a, input logic [31:0] d,
                         input logic [2:0] en, input int a0, input int a1, input int a2);
        we      = w;
        wa      = a[ADDR_W-1:0];
        wd      = d;
        rd_en   = en;
        rd_addr = {a2[ADDR_W-1:0], a1[ADDR_W-1:0], a0[ADDR_W-1:0]};
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && (int'(wa) == a)) return wd;
`endif
        return mem[a];
    endfunction

    // One clock: predict from the inputs in force, then compare after the edge.
    task automatic step();
        bit rdy;
        rdy = (edges_since_rst >= DEPTH);
        for (int p = 0; p < NUM_RD; p++) begin
            if (rdy && rd_en[p]) begin
                exp_data[p]  = model_read(int'(rd_addr[p*ADDR_W +: ADDR_W]));
                exp_valid[p] = 1'b1;
            end else begin
                exp_valid[p] = 1'b0;
            end
        end
        if (rdy && we && (wa != '0)) mem[wa] = wd;
        @(posedge clk);
        #1;
        edges_since_rst++;
        check("ready", {31'd0, ready}, {31'd0, (edges_since_rst >= DEPTH)});
        for (int p = 0; p < NUM_RD; p++) begin
            check($sformatf("valid%0d", p), {31'd0, rd_valid[p]}, {31'd0, exp_valid[p]});
            check($sformatf("data%0d", p), rd_data[p*DATA_W +: DATA_W], exp_data[p]);
        end
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        #1;
        edges_since_rst = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        for (int p = 0; p < NUM_RD; p++) begin
            exp_data[p]  = 32'h0;
            exp_valid[p] = 1'b0;
        end
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {29'd0, rd_valid}, 32'd0);
        check("rst_data0", rd_data[31:0], 32'h0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        apply_reset(2);

        // Sweep: accesses ignored, READY low for 32 cycles then high.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, $urandom_range(1, 31), $urandom, 3'($urandom),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            step();
            if (i == DEPTH - 2) check("t1_ready_c31", {31'd0, ready}, 32'd0);
        end
        check("t1_ready_c33", {31'd0, ready}, 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 0, 32'h0, 3'b111, a, a, a);
            step();
            check("t1_zero", rd_data[DATA_W +: DATA_W], 32'h0);
        end

        // Write then read back.
        drive(1'b1, 5, 32'hDEADBEEF, 3'b000, 0, 0, 0);
        step();
        drive(1'b0, 0, 32'h0, 3'b001, 5, 0, 0);
        step();
        check("t2_data", rd_data[31:0], 32'hDEADBEEF);
        check("t2_valid", {29'd0, rd_valid}, 32'd1);

        // WE=0 drops the write; writes to register 0 are discarded.
        drive(1'b0, 7, 32'h12345678, 3'b000, 0, 0, 0);
        step();
        drive(1'b1, 0, 32'hFFFFFFFF, 3'b000, 0, 0, 0);
        step();
        drive(1'b0, 0, 32'h0, 3'b011, 7, 0, 0);
        step();
        check("t3_we0", rd_data[31:0], 32'h0);
        check("t3_zero", rd_data[63:32], 32'h0);

        // Same-cycle read and write of one address.
        drive(1'b1, 3, 32'h11, 3'b000, 0, 0, 0);
        step();
        drive(1'b1, 3, 32'h22, 3'b010, 0, 3, 0);
        step();
`ifdef REGFILE_BYPASS_EN
        check("t4_raw", rd_data[63:32], 32'h22);
`else
        check("t4_raw", rd_data[63:32], 32'h11);
`endif
        drive(1'b0, 0, 32'h0, 3'b010, 0, 3, 0);
        step();
        check("t4_next", rd_data[63:32], 32'h22);

        // Three ports at once, two sharing an address.
        drive(1'b1, 1, 32'h1111, 3'b000, 0, 0, 0);
        step();
        drive(1'b1, 2, 32'h2222, 3'b000, 0, 0, 0);
        step();
        drive(1'b0, 0, 32'h0, 3'b111, 1, 1, 2);
        step();
        check("t6_valid", {29'd0, rd_valid}, 32'd7);
        check("t6_p0", rd_data[31:0], 32'h1111);
        check("t6_p1", rd_data[63:32], 32'h1111);
        check("t6_p2", rd_data[95:64], 32'h2222);

        // Hold-on-idle: a disabled port keeps its last value.
        drive(1'b0, 0, 32'h0, 3'b000, 5, 5, 5);
        step();
        check("hold_p2", rd_data[95:64], 32'h2222);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), $urandom_range(0, 7), $urandom, 3'($urandom),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            step();
        end

        // Reset mid-RUN with WE held through the sweep.
        drive(1'b1, 9, 32'hAA, 3'b000, 0, 0, 0);
        step();
        drive(1'b1, 9, 32'h55, 3'b111, 9, 9, 9);
        apply_reset(1);
        for (int i = 0; i < DEPTH; i++) step();
        drive(1'b0, 0, 32'h0, 3'b001, 9, 0, 0);
        step();
        check("t5_reg9", rd_data[31:0], 32'h0);
        check("t5_valid", {29'd0, rd_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
